// File: rtl/specify_path_delay_filter.sv
// Multi-channel module path delay with inertial pulse rejection and error reporting.
// Latency: an input change sampled on edge k reaches the output on edge k+d (d = rise/fall delay, 0 treated as 1).
// No backpressure: every channel accepts its input every cycle; busy reports an uncommitted transition.
module specify_path_delay_filter #(
  parameter int          N         = 4,
  parameter int          DW        = 8,
  parameter logic [N-1:0] RESET_VAL = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  in,
  input  logic [DW-1:0] rise_dly,
  input  logic [DW-1:0] fall_dly,
  input  logic [DW-1:0] rej_lim,
  input  logic          err_clr,
  output logic [N-1:0]  out,
  output logic [N-1:0]  busy,
  output logic [N-1:0]  err_pulse,
  output logic [N-1:0]  err_sticky
);

  // Per-channel state: pend is the IDLE/PEND state bit of each channel's FSM
  logic [N-1:0]  pend_q, pend_d;
  logic [N-1:0]  tgt_q, tgt_d;
  logic [N-1:0]  out_q, out_d;
  logic [N-1:0]  ep_q, ep_d;
  logic [N-1:0]  es_q, es_d;
  logic [DW-1:0] cnt_q [N];
  logic [DW-1:0] cnt_d [N];

  // Effective delays, with a zero delay behaving as a single cycle
  logic [DW-1:0] rise_eff;
  logic [DW-1:0] fall_eff;
  logic [DW-1:0] d_eff [N];

  // Delay select: a channel's delay follows the direction of its scheduled target
  always_comb begin
    rise_eff = (rise_dly == '0) ? DW'(1) : rise_dly;
    fall_eff = (fall_dly == '0) ? DW'(1) : fall_dly;
    for (int i = 0; i < N; i++) begin
      d_eff[i] = tgt_q[i] ? rise_eff : fall_eff;
    end
  end

  // State register: all channel state, reset asynchronously even mid-transition
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= '0;
      tgt_q  <= RESET_VAL;
      out_q  <= RESET_VAL;
      ep_q   <= '0;
      es_q   <= '0;
      for (int i = 0; i < N; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      pend_q <= pend_d;
      tgt_q  <= tgt_d;
      out_q  <= out_d;
      ep_q   <= ep_d;
      es_q   <= es_d;
      for (int i = 0; i < N; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // Next-state logic: schedule, count, commit or cancel each channel independently
  always_comb begin
    pend_d = pend_q;
    tgt_d  = tgt_q;
    out_d  = out_q;
    ep_d   = '0;
    for (int i = 0; i < N; i++) begin
      cnt_d[i] = cnt_q[i];
    end
    for (int i = 0; i < N; i++) begin
      if (!pend_q[i]) begin
        if (in[i] != out_q[i]) begin
          pend_d[i] = 1'b1;
          tgt_d[i]  = in[i];
          cnt_d[i]  = DW'(1);
        end
      end else if (in[i] == tgt_q[i]) begin
        // A lowered delay that is already covered by cnt commits right away
        if (cnt_q[i] >= d_eff[i]) begin
          out_d[i]  = tgt_q[i];
          pend_d[i] = 1'b0;
        end else begin
          cnt_d[i] = cnt_q[i] + DW'(1);
        end
      end else begin
        // Input reverted before commit: cnt holds the width of the cancelled pulse.
        // With one-bit channels a revert always lands back on out_q, so no reschedule is needed.
        pend_d[i] = 1'b0;
        if (cnt_q[i] >= rej_lim) begin
          ep_d[i] = 1'b1;
        end
      end
    end
    // A new error in the same cycle as a clear keeps the sticky bit set
    es_d = (es_q & ~{N{err_clr}}) | ep_d;
  end

  // Outputs: all directly registered
  always_comb begin
    out        = out_q;
    busy       = pend_q;
    err_pulse  = ep_q;
    err_sticky = es_q;
  end

endmodule

// File: tb/tb_specify_path_delay_filter.sv
// Directed bench for specify_path_delay_filter with a run-length reference model.
// The model derives outputs from how long each input has held its value since it last changed.
// All checks sample on the falling clock edge; inputs are driven on the falling edge.
module tb_specify_path_delay_filter;

  localparam int          N  = 4;
  localparam int          DW = 8;
  localparam logic [N-1:0] RV = '0;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  in = '0;
  logic [DW-1:0] rise_dly = 8'd5;
  logic [DW-1:0] fall_dly = 8'd3;
  logic [DW-1:0] rej_lim = 8'd2;
  logic          err_clr = 1'b0;
  logic [N-1:0]  out, busy, err_pulse, err_sticky;

  int pass_cnt = 0;
  int total_cnt = 0;

  specify_path_delay_filter #(.N(N), .DW(DW), .RESET_VAL(RV)) dut (
    .clk(clk), .rst_n(rst_n), .in(in),
    .rise_dly(rise_dly), .fall_dly(fall_dly), .rej_lim(rej_lim), .err_clr(err_clr),
    .out(out), .busy(busy), .err_pulse(err_pulse), .err_sticky(err_sticky)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Reference model: run[i] counts consecutive samples of the current input value.
  // The output takes a new value once that value has been seen for more than d samples;
  // a value that differed from the output and then changed back is a cancelled pulse of width run.
  logic [N-1:0] m_out, m_prev, m_busy, m_ep, m_es;
  int           run [N];
  logic         mv, me;
  int           md;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_out = RV; m_prev = RV; m_busy = '0; m_ep = '0; m_es = '0;
      for (int i = 0; i < N; i++) run[i] = 0;
    end else begin
      for (int i = 0; i < N; i++) begin
        mv = in[i];
        me = 1'b0;
        if (mv == m_prev[i]) begin
          run[i] = run[i] + 1;
        end else begin
          if (m_prev[i] != m_out[i] && run[i] >= int'(rej_lim)) me = 1'b1;
          run[i] = 1;
        end
        md = mv ? int'(rise_dly) : int'(fall_dly);
        if (md == 0) md = 1;
        if (mv != m_out[i] && run[i] - 1 >= md) m_out[i] = mv;
        m_prev[i] = mv;
        m_busy[i] = (mv != m_out[i]);
        m_ep[i]   = me;
        m_es[i]   = (m_es[i] & ~err_clr) | me;
      end
    end
  end

  // Every-cycle comparison of all outputs against the model
  always @(negedge clk) begin
    chk("model_out", out, m_out);
    chk("model_busy", busy, m_busy);
    chk("model_err_pulse", err_pulse, m_ep);
    chk("model_err_sticky", err_sticky, m_es);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    step(2);
    chk("reset_out", out, RV);
    chk("reset_busy", busy, 0);
    chk("reset_err_pulse", err_pulse, 0);
    chk("reset_err_sticky", err_sticky, 0);
    rst_n = 1'b1;
    step(1);

    // Rise delay 5, fall delay 3
    in[0] = 1'b1;
    step(5); chk("rise5_before", out[0], 0);
    chk("rise5_busy", busy[0], 1);
    step(1); chk("rise5_at", out[0], 1);
    step(4);
    in[0] = 1'b0;
    step(3); chk("fall3_before", out[0], 1);
    step(1); chk("fall3_at", out[0], 0);
    chk("risefall_no_err", err_sticky, 0);

    // Pulse filtering with delay 6 and reject limit 2
    rise_dly = 8'd6; fall_dly = 8'd6; rej_lim = 8'd2;
    step(2);
    in[0] = 1'b1; step(1); in[0] = 1'b0;
    step(1); chk("pulse1_no_err", err_pulse[0], 0);
    step(1); chk("pulse1_out", out[0], 0);
    chk("pulse1_sticky", err_sticky[0], 0);

    in[0] = 1'b1; step(4); in[0] = 1'b0;
    step(1); chk("pulse4_err", err_pulse[0], 1);
    chk("pulse4_sticky", err_sticky[0], 1);
    chk("pulse4_out", out[0], 0);
    step(1); chk("pulse4_err_one_cycle", err_pulse[0], 0);
    chk("pulse4_sticky_held", err_sticky[0], 1);

    err_clr = 1'b1; step(1); err_clr = 1'b0;
    chk("clear_sticky", err_sticky[0], 0);

    // Six samples high against d=6: commit needs the value on the 7th edge, so this is cancelled with w=6
    in[0] = 1'b1; step(6); in[0] = 1'b0;
    step(1); chk("pulse6_err", err_pulse[0], 1);
    chk("pulse6_out", out[0], 0);
    err_clr = 1'b1; step(1); err_clr = 1'b0;

    // Seven samples high propagate as a seven-cycle output pulse delayed by 6
    in[0] = 1'b1;
    step(6); chk("pulse7_before", out[0], 0);
    step(1); chk("pulse7_rise", out[0], 1);
    in[0] = 1'b0;
    step(6); chk("pulse7_still_high", out[0], 1);
    step(1); chk("pulse7_fall", out[0], 0);
    chk("pulse7_no_err", err_sticky[0], 0);

    // Zero rise delay behaves as one cycle
    rise_dly = 8'd0; fall_dly = 8'd3;
    step(1);
    in[0] = 1'b1;
    step(1); chk("rise0_before", out[0], 0);
    step(1); chk("rise0_at", out[0], 1);
    in[0] = 1'b0;
    step(4); chk("rise0_fall_back", out[0], 0);

    // Reject limit 0: even a one-cycle cancelled pulse is an error
    rise_dly = 8'd4; rej_lim = 8'd0;
    in[0] = 1'b1; step(1); in[0] = 1'b0;
    step(1); chk("rej0_err", err_pulse[0], 1);
    step(1);

    // Reject limit 10 above delay 4: a 4-sample cancelled pulse is silent
    err_clr = 1'b1; step(1); err_clr = 1'b0;
    rej_lim = 8'd10;
    in[0] = 1'b1; step(4); in[0] = 1'b0;
    step(1); chk("rej10_no_err", err_pulse[0], 0);
    step(1); chk("rej10_sticky", err_sticky[0], 0);

    // Sticky collision: clear and set on the same edge, then clear alone
    rej_lim = 8'd2; rise_dly = 8'd6;
    in[0] = 1'b1; step(3); in[0] = 1'b0; err_clr = 1'b1;
    step(1); chk("collide_err", err_pulse[0], 1);
    chk("collide_set_wins", err_sticky[0], 1);
    step(1); chk("collide_cleared", err_sticky[0], 0);
    err_clr = 1'b0;

    // Mid-flight reconfiguration on ch1 while ch2 falls independently
    rise_dly = 8'd0; fall_dly = 8'd3;
    in[2] = 1'b1; step(3); chk("ch2_up", out[2], 1);
    rise_dly = 8'd8;
    in[1] = 1'b1; in[2] = 1'b0;
    step(3); chk("ch2_fall_before", out[2], 1);
    step(1); chk("ch2_fall_at", out[2], 0);
    chk("ch1_pending", busy[1], 1);
    chk("ch1_not_yet", out[1], 0);
    rise_dly = 8'd3;
    step(1); chk("ch1_commit_after_lower", out[1], 1);
    chk("ch1_idle", busy[1], 0);

    // Asynchronous reset with ch0 pending at cnt=3 and an error latched on ch3
    rise_dly = 8'd8; rej_lim = 8'd2;
    in[3] = 1'b1; step(1);
    in[0] = 1'b1; step(2);
    in[3] = 1'b0; step(1);
    chk("pre_reset_busy0", busy[0], 1);
    chk("pre_reset_sticky3", err_sticky[3], 1);
    #1 rst_n = 1'b0;
    #1;
    chk("async_reset_out", out, RV);
    chk("async_reset_busy", busy, 0);
    chk("async_reset_sticky", err_sticky, 0);
    chk("async_reset_err_pulse", err_pulse, 0);
    in = '0;
    step(2);
    rst_n = 1'b1;
    step(3); chk("post_reset_out", out, RV);

    // After release, a value differing from the reset value schedules normally
    rise_dly = 8'd2;
    in[0] = 1'b1;
    step(2); chk("post_reset_before", out[0], 0);
    step(1); chk("post_reset_rise", out[0], 1);
    step(2);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
